// File: rtl/axis_packet_header_strip_if.sv
// AXI-Stream bundle used on both sides of the header stripper.
// master drives data/valid/last/keep; slave drives ready.
interface axis_packet_header_strip_if #(
    parameter int PHIT_SIZE = 512
);
    logic [PHIT_SIZE-1:0]   tdata;
    logic                   tvalid;
    logic                   tready;
    logic                   tlast;
    logic [PHIT_SIZE/8-1:0] tkeep;

    modport master (output tdata, output tvalid, output tlast, output tkeep, input tready);
    modport slave  (input tdata, input tvalid, input tlast, input tkeep, output tready);
endinterface

// File: rtl/axis_packet_header_strip.sv
// Checks and strips the header beat of fixed-length packets and forwards the payload through a 2-entry skid.
// Optional macro DROP_BAD_PKT_EN: discard whole packets whose header magic is wrong.
module axis_packet_header_strip #(
    parameter int          PHIT_SIZE     = 512,
    parameter int          PACKET_LENGTH = 32,
    parameter logic [31:0] HEADER_MAGIC  = 32'h12345678
) (
    input  logic                          ap_clk,
    input  logic                          rst,
    axis_packet_header_strip_if.slave     s_axis,
    axis_packet_header_strip_if.master    m_axis,
    output logic                          hdr_err,
    output logic                          len_err,
    output logic [31:0]                   pkt_count,
    output logic [15:0]                   err_count
);
    localparam int KEEP_W = PHIT_SIZE / 8;
    localparam int CNT_W  = $clog2(PACKET_LENGTH + 1);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PACKET_LENGTH - 1);

    typedef enum logic [1:0] {
        HEADER,
        PAYLOAD
`ifdef DROP_BAD_PKT_EN
        , DROP
`endif
    } state_t;

    state_t             state, state_n;
    logic [CNT_W-1:0]   beat_cnt, beat_cnt_n;
    logic               s_ready_q, s_ready_n;
    logic               accept, hdr_ok, at_end;
    logic               push, push_last;
    logic               hdr_err_n, len_err_n;
    logic               out_load, skid_valid_n;

    logic               out_valid, out_last;
    logic [PHIT_SIZE-1:0] out_data;
    logic [KEEP_W-1:0]  out_keep;
    logic               skid_valid, skid_last;
    logic [PHIT_SIZE-1:0] skid_data;
    logic [KEEP_W-1:0]  skid_keep;

    always_ff @(posedge ap_clk) begin
        if (rst) begin
            state    <= HEADER;
            beat_cnt <= '0;
        end else begin
            state    <= state_n;
            beat_cnt <= beat_cnt_n;
        end
    end

    always_comb begin
        state_n    = state;
        beat_cnt_n = beat_cnt;
        push       = 1'b0;
        push_last  = 1'b0;
        hdr_err_n  = 1'b0;
        len_err_n  = 1'b0;
        accept     = s_axis.tvalid && s_ready_q;
        hdr_ok     = (s_axis.tdata[31:0] == HEADER_MAGIC);
        at_end     = (beat_cnt == LAST_IDX);
        case (state)
            HEADER: begin
                if (accept) begin
                    hdr_err_n = !hdr_ok;
                    // A header that already ends the packet carries no payload: stay and re-parse.
                    if (s_axis.tlast) begin
                        len_err_n = 1'b1;
                    end else if (hdr_ok) begin
                        state_n    = PAYLOAD;
                        beat_cnt_n = CNT_W'(1);
                    end else begin
`ifdef DROP_BAD_PKT_EN
                        state_n    = DROP;
`else
                        state_n    = PAYLOAD;
                        beat_cnt_n = CNT_W'(1);
`endif
                    end
                end
            end
            PAYLOAD: begin
                if (accept) begin
                    push      = 1'b1;
                    push_last = s_axis.tlast || at_end;
                    len_err_n = (s_axis.tlast != at_end);
                    if (push_last) begin
                        state_n    = HEADER;
                        beat_cnt_n = '0;
                    end else begin
                        beat_cnt_n = beat_cnt + CNT_W'(1);
                    end
                end
            end
`ifdef DROP_BAD_PKT_EN
            DROP: begin
                if (accept && s_axis.tlast) begin
                    state_n = HEADER;
                end
            end
`endif
            default: begin
                state_n = HEADER;
            end
        endcase
    end

    // Ready is registered from the next skid occupancy, so m_axis.tready never reaches s_axis.tready combinationally.
    assign out_load     = !out_valid || m_axis.tready;
    assign skid_valid_n = out_load ? 1'b0 : (skid_valid || push);
    assign s_ready_n    = (state_n != PAYLOAD) || !skid_valid_n;

    always_ff @(posedge ap_clk) begin
        if (rst) begin
            s_ready_q  <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            out_data   <= '0;
            out_keep   <= '0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_data  <= '0;
            skid_keep  <= '0;
            hdr_err    <= 1'b0;
            len_err    <= 1'b0;
            pkt_count  <= '0;
            err_count  <= '0;
        end else begin
            s_ready_q  <= s_ready_n;
            skid_valid <= skid_valid_n;
            hdr_err    <= hdr_err_n;
            len_err    <= len_err_n;
            if (out_load) begin
                if (skid_valid) begin
                    out_valid <= 1'b1;
                    out_last  <= skid_last;
                    out_data  <= skid_data;
                    out_keep  <= skid_keep;
                end else if (push) begin
                    out_valid <= 1'b1;
                    out_last  <= push_last;
                    out_data  <= s_axis.tdata;
                    out_keep  <= s_axis.tkeep;
                end else begin
                    out_valid <= 1'b0;
                end
            end else if (push) begin
                skid_last <= push_last;
                skid_data <= s_axis.tdata;
                skid_keep <= s_axis.tkeep;
            end
            if (out_valid && m_axis.tready && out_last) begin
                pkt_count <= pkt_count + 32'd1;
            end
            if ((hdr_err_n || len_err_n) && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    assign s_axis.tready = s_ready_q;
    assign m_axis.tvalid = out_valid;
    assign m_axis.tlast  = out_last;
    assign m_axis.tdata  = out_data;
    assign m_axis.tkeep  = out_keep;
endmodule
